// File: rtl/pwm_multi_timer_if.sv
// pwm_multi_timer_if
// Bundles the configuration inputs and timer outputs of pwm_multi_timer.
//   enable   : run/stop
//   period   : terminal count P (counter runs 0..P)
//   prescale : divider N, one tick every N+1 clocks
//   duty     : packed per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   load     : one-clock strobe capturing period/prescale/duty into shadow
//   tick     : prescaler expiry strobe
//   wrap     : period-boundary strobe
//   count    : current counter value
//   pwm_out  : one PWM output per channel
// Modports: master drives configuration (register side), slave is the timer.
interface pwm_multi_timer_if #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 10,
  parameter int PRESCALE_W = 8
);
  logic                      enable;
  logic [WIDTH-1:0]          period;
  logic [PRESCALE_W-1:0]     prescale;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      load;
  logic                      tick;
  logic                      wrap;
  logic [WIDTH-1:0]          count;
  logic [CHANNELS-1:0]       pwm_out;

  modport master (
    output enable, period, prescale, duty, load,
    input  tick, wrap, count, pwm_out
  );

  modport slave (
    input  enable, period, prescale, duty, load,
    output tick, wrap, count, pwm_out
  );
endinterface

// File: rtl/pwm_multi_timer.sv
// pwm_multi_timer
// Multi-channel PWM timebase: a prescaled, programmable-period counter shared
// by CHANNELS duty comparators. Period, prescale and duty are double-buffered
// (shadow -> active) and commit only at a period boundary, or immediately
// while the timer is stopped, so outputs never glitch on reconfiguration.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : pwm_multi_timer_if.slave (enable, period, prescale, duty, load
//           in; tick, wrap, count, pwm_out out)
// Configuration macro:
//   PWM_CENTER_ALIGNED_EN : when defined the counter runs an up/down triangle
//   0..P..0 and wrap marks the 1->0 step; otherwise edge-aligned sawtooth.
module pwm_multi_timer #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 10,
  parameter int PRESCALE_W = 8
) (
  input logic              clk,
  input logic              reset,
  pwm_multi_timer_if.slave bus
);

  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

  // Shadow (load-written) configuration
  logic [WIDTH-1:0]          sh_period_q,    sh_period_d;
  logic [PRESCALE_W-1:0]     sh_prescale_q,  sh_prescale_d;
  logic [CHANNELS*WIDTH-1:0] sh_duty_q,      sh_duty_d;
  logic                      pending_q,      pending_d;
  // Active configuration used by the datapath
  logic [WIDTH-1:0]          act_period_q,   act_period_d;
  logic [PRESCALE_W-1:0]     act_prescale_q, act_prescale_d;
  logic [CHANNELS*WIDTH-1:0] act_duty_q,     act_duty_d;
  // Datapath state
  logic [PRESCALE_W-1:0]     pcnt_q,         pcnt_d;
  logic [WIDTH-1:0]          count_q,        count_d;
  logic [CHANNELS-1:0]       pwm_q,          pwm_d;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                      dir_down_q,     dir_down_d;
`endif

  logic tick_s;
  logic wrap_s;
  logic commit_s;

  // Prescaler, counter, shadow/active commit and duty comparators
  always_comb begin
    sh_period_d    = sh_period_q;
    sh_prescale_d  = sh_prescale_q;
    sh_duty_d      = sh_duty_q;
    pending_d      = pending_q;
    act_period_d   = act_period_q;
    act_prescale_d = act_prescale_q;
    act_duty_d     = act_duty_q;
    pcnt_d         = pcnt_q;
    count_d        = count_q;
    pwm_d          = pwm_q;
    tick_s         = 1'b0;
    wrap_s         = 1'b0;
    commit_s       = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_down_d     = dir_down_q;
`endif

    // ">=" rather than "==" so a value committed while stopped that is
    // already below the held pcnt/count cannot run the counter past it.
    if (bus.enable && !reset && (pcnt_q >= act_prescale_q)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end

    if (bus.enable) begin
      if (tick_s) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PCNT_ONE;
      end
    end else begin
      pcnt_d = pcnt_q;
    end

`ifdef PWM_CENTER_ALIGNED_EN
    // Triangle: turn down at P, turn up after reaching 0; wrap on 1->0.
    if (tick_s) begin
      if (act_period_q == '0) begin
        count_d    = '0;
        dir_down_d = 1'b0;
        wrap_s     = 1'b1;
      end else if (count_q >= act_period_q) begin
        count_d    = act_period_q - CNT_ONE;
        dir_down_d = 1'b1;
        wrap_s     = (act_period_q == CNT_ONE);
      end else if (dir_down_q) begin
        if (count_q == '0) begin
          count_d    = CNT_ONE;
          dir_down_d = 1'b0;
        end else begin
          count_d = count_q - CNT_ONE;
          wrap_s  = (count_q == CNT_ONE);
        end
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
`else
    // Sawtooth 0..P, wrapping to 0 on the terminal tick.
    if (tick_s) begin
      if (count_q >= act_period_q) begin
        count_d = '0;
        wrap_s  = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
`endif

    commit_s = pending_q && (wrap_s || !bus.enable);

    if (bus.load) begin
      sh_period_d   = bus.period;
      sh_prescale_d = bus.prescale;
      sh_duty_d     = bus.duty;
    end else begin
      sh_period_d   = sh_period_q;
      sh_prescale_d = sh_prescale_q;
      sh_duty_d     = sh_duty_q;
    end

    // A load landing on the wrap cycle bypasses the shadow stage entirely.
    if (bus.load && wrap_s) begin
      act_period_d   = bus.period;
      act_prescale_d = bus.prescale;
      act_duty_d     = bus.duty;
      pending_d      = 1'b0;
    end else if (commit_s) begin
      act_period_d   = sh_period_q;
      act_prescale_d = sh_prescale_q;
      act_duty_d     = sh_duty_q;
      pending_d      = bus.load;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (count_q < act_duty_q[i*WIDTH +: WIDTH]);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_period_q    <= '0;
      sh_prescale_q  <= '0;
      sh_duty_q      <= '0;
      pending_q      <= 1'b0;
      act_period_q   <= '0;
      act_prescale_q <= '0;
      act_duty_q     <= '0;
      pcnt_q         <= '0;
      count_q        <= '0;
      pwm_q          <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_down_q     <= 1'b0;
`endif
    end else begin
      sh_period_q    <= sh_period_d;
      sh_prescale_q  <= sh_prescale_d;
      sh_duty_q      <= sh_duty_d;
      pending_q      <= pending_d;
      act_period_q   <= act_period_d;
      act_prescale_q <= act_prescale_d;
      act_duty_q     <= act_duty_d;
      pcnt_q         <= pcnt_d;
      count_q        <= count_d;
      pwm_q          <= pwm_d;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_down_q     <= dir_down_d;
`endif
    end
  end

  assign bus.tick    = tick_s;
  assign bus.wrap    = wrap_s;
  assign bus.count   = count_q;
  assign bus.pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_multi_timer.sv
// Directed self-checking bench for pwm_multi_timer (CHANNELS=4, WIDTH=10,
// PRESCALE_W=8). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
module tb_pwm_multi_timer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  pwm_multi_timer_if #(.CHANNELS(4), .WIDTH(10), .PRESCALE_W(8)) bus_if ();

  pwm_multi_timer #(.CHANNELS(4), .WIDTH(10), .PRESCALE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Load a configuration while stopped and wait until it is active.
  task automatic load_stopped(input logic [9:0] p, input logic [7:0] n,
                              input logic [39:0] d);
    next_cycle();
    bus_if.enable   = 1'b0;
    bus_if.load     = 1'b1;
    bus_if.period   = p;
    bus_if.prescale = n;
    bus_if.duty     = d;
    next_cycle();
    bus_if.load = 1'b0;
    next_cycle();
  endtask

  function automatic int mid_count(input int j);
    if (j < 0)       return 0;
    else if (j < 10) return j;
    else             return (j - 10) % 5;
  endfunction

  task automatic test_reset();
    for (int r = 0; r < 2; r++) begin
      next_cycle();
      reset           = 1'b1;
      bus_if.enable   = 1'b1;
      bus_if.load     = 1'b1;
      bus_if.period   = 10'($urandom_range(1, 1023));
      bus_if.prescale = 8'($urandom);
      bus_if.duty     = 40'({$urandom, $urandom});
      @(negedge clk);
      n_checks++;
      if (bus_if.count !== 10'd0) begin
        n_fails++; $display("FAIL reset_count: got %0d expected 0", bus_if.count);
      end
      n_checks++;
      if (bus_if.pwm_out !== 4'b0000) begin
        n_fails++; $display("FAIL reset_pwm: got %b expected 0000", bus_if.pwm_out);
      end
      n_checks++;
      if ({bus_if.tick, bus_if.wrap} !== 2'b00) begin
        n_fails++; $display("FAIL reset_tick_wrap: got %b expected 00", {bus_if.tick, bus_if.wrap});
      end
    end
    next_cycle();
    reset         = 1'b0;
    bus_if.load   = 1'b0;
    bus_if.enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_if.tick, bus_if.wrap, bus_if.count} !== 12'd0) begin
      n_fails++; $display("FAIL post_reset_idle: got %b expected 0", {bus_if.tick, bus_if.wrap, bus_if.count});
    end
    next_cycle();
    // Loads during reset must be gone: active P=0, N=0 -> count stays 0, wrap every clk.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus_if.count !== 10'd0 || bus_if.wrap !== 1'b1 || bus_if.tick !== 1'b1) begin
        n_fails++;
        $display("FAIL reset_load_ignored: got count=%0d wrap=%b tick=%b expected count=0 wrap=1 tick=1",
                 bus_if.count, bus_if.wrap, bus_if.tick);
      end
      n_checks++;
      if (bus_if.pwm_out !== 4'b0000) begin
        n_fails++; $display("FAIL reset_duty_zero: got %b expected 0000", bus_if.pwm_out);
      end
    end
  endtask

  task automatic test_stopped_load();
    int pc;
    logic [3:0] exp_pwm;
    load_stopped(10'd9, 8'd0, {10'd5, 10'd10, 10'd0, 10'd3});
    for (int k = 0; k < 30; k++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      @(negedge clk);
      pc = (k == 0) ? 0 : (k - 1) % 10;
      exp_pwm = {(pc < 5), 1'b1, 1'b0, (pc < 3)};
      n_checks++;
      if (bus_if.count !== 10'(k % 10)) begin
        n_fails++; $display("FAIL stopped_count k=%0d: got %0d expected %0d", k, bus_if.count, k % 10);
      end
      n_checks++;
      if (bus_if.wrap !== ((k % 10) == 9) || bus_if.tick !== 1'b1) begin
        n_fails++; $display("FAIL stopped_wrap k=%0d: got wrap=%b tick=%b expected wrap=%b tick=1",
                            k, bus_if.wrap, bus_if.tick, ((k % 10) == 9));
      end
      n_checks++;
      if (bus_if.pwm_out !== exp_pwm) begin
        n_fails++; $display("FAIL stopped_pwm k=%0d: got %b expected %b", k, bus_if.pwm_out, exp_pwm);
      end
    end
  endtask

  task automatic test_prescale();
    int pc;
    int highs;
    highs = 0;
    load_stopped(10'd9, 8'd2, {10'd5, 10'd10, 10'd0, 10'd3});
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      @(negedge clk);
      pc = (k == 0) ? 0 : ((k - 1) / 3) % 10;
      if (k >= 1 && k <= 30 && bus_if.pwm_out[0] === 1'b1) highs++;
      n_checks++;
      if (bus_if.count !== 10'((k / 3) % 10)) begin
        n_fails++; $display("FAIL prescale_count k=%0d: got %0d expected %0d", k, bus_if.count, (k / 3) % 10);
      end
      n_checks++;
      if (bus_if.tick !== ((k % 3) == 2) || bus_if.wrap !== ((k % 30) == 29)) begin
        n_fails++; $display("FAIL prescale_tick_wrap k=%0d: got tick=%b wrap=%b expected tick=%b wrap=%b",
                            k, bus_if.tick, bus_if.wrap, ((k % 3) == 2), ((k % 30) == 29));
      end
      n_checks++;
      if (bus_if.pwm_out[0] !== (pc < 3)) begin
        n_fails++; $display("FAIL prescale_pwm0 k=%0d: got %b expected %b", k, bus_if.pwm_out[0], (pc < 3));
      end
    end
    n_checks++;
    if (highs != 9) begin
      n_fails++; $display("FAIL prescale_duty_count: got %0d high clocks expected 9", highs);
    end
  endtask

  task automatic test_midperiod_reload();
    int pc;
    int pd;
    load_stopped(10'd9, 8'd0, {10'd5, 10'd10, 10'd0, 10'd3});
    for (int k = 0; k < 30; k++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      bus_if.load   = (k == 5);
      if (k == 5) begin
        bus_if.period = 10'd4;
        bus_if.duty   = {10'd5, 10'd10, 10'd0, 10'd2};
      end
      @(negedge clk);
      pc = mid_count(k - 1);
      pd = (k - 1 < 10) ? 3 : 2;
      n_checks++;
      if (bus_if.count !== 10'(mid_count(k))) begin
        n_fails++; $display("FAIL mid_count k=%0d: got %0d expected %0d", k, bus_if.count, mid_count(k));
      end
      n_checks++;
      if (bus_if.wrap !== ((k < 10) ? (k == 9) : (((k - 10) % 5) == 4))) begin
        n_fails++; $display("FAIL mid_wrap k=%0d: got %b", k, bus_if.wrap);
      end
      n_checks++;
      if (bus_if.pwm_out[0] !== (pc < pd)) begin
        n_fails++; $display("FAIL mid_pwm0 k=%0d: got %b expected %b", k, bus_if.pwm_out[0], (pc < pd));
      end
    end
    bus_if.load = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ec;
    logic ew;
    // Active P=4 with count 0; load P=7 exactly on the wrap cycle.
    for (int k = 0; k < 21; k++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      bus_if.load   = (k == 4);
      if (k == 4) bus_if.period = 10'd7;
      @(negedge clk);
      ec = (k < 5) ? k : (k - 5) % 8;
      ew = (k == 4) || (k >= 5 && ((k - 5) % 8) == 7);
      n_checks++;
      if (bus_if.count !== 10'(ec) || bus_if.wrap !== ew) begin
        n_fails++; $display("FAIL loadwrap k=%0d: got count=%0d wrap=%b expected count=%0d wrap=%b",
                            k, bus_if.count, bus_if.wrap, ec, ew);
      end
    end
    // Pending load P=3 at count 2, then reset at count 6.
    for (int j = 0; j < 7; j++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      bus_if.load   = (j == 2);
      if (j == 2) bus_if.period = 10'd3;
      reset = (j == 6);
      @(negedge clk);
      n_checks++;
      if (bus_if.count !== 10'(j)) begin
        n_fails++; $display("FAIL prereset_count j=%0d: got %0d expected %0d", j, bus_if.count, j);
      end
    end
    n_checks++;
    if (bus_if.tick !== 1'b0) begin
      n_fails++; $display("FAIL reset_gates_tick: got %b expected 0", bus_if.tick);
    end
    next_cycle();
    reset         = 1'b0;
    bus_if.enable = 1'b0;
    bus_if.load   = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_if.count, bus_if.pwm_out, bus_if.tick, bus_if.wrap} !== 16'd0) begin
      n_fails++; $display("FAIL midrun_reset: got count=%0d pwm=%b tick=%b wrap=%b expected all 0",
                          bus_if.count, bus_if.pwm_out, bus_if.tick, bus_if.wrap);
    end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus_if.count !== 10'd0 || bus_if.wrap !== 1'b1) begin
        n_fails++; $display("FAIL pending_lost k=%0d: got count=%0d wrap=%b expected count=0 wrap=1",
                            k, bus_if.count, bus_if.wrap);
      end
    end
  endtask

`ifdef PWM_CENTER_ALIGNED_EN
  task automatic test_center();
    int t;
    int ec;
    int pc;
    load_stopped(10'd4, 8'd0, {10'd0, 10'd0, 10'd0, 10'd2});
    for (int k = 0; k < 24; k++) begin
      next_cycle();
      bus_if.enable = 1'b1;
      @(negedge clk);
      t  = k % 8;
      ec = (t <= 4) ? t : 8 - t;
      t  = (k == 0) ? 0 : (k - 1) % 8;
      pc = (t <= 4) ? t : 8 - t;
      n_checks++;
      if (bus_if.count !== 10'(ec) || bus_if.wrap !== ((k % 8) == 7)) begin
        n_fails++; $display("FAIL center k=%0d: got count=%0d wrap=%b expected count=%0d wrap=%b",
                            k, bus_if.count, bus_if.wrap, ec, ((k % 8) == 7));
      end
      n_checks++;
      if (bus_if.pwm_out[0] !== (pc < 2)) begin
        n_fails++; $display("FAIL center_pwm0 k=%0d: got %b expected %b", k, bus_if.pwm_out[0], (pc < 2));
      end
    end
  endtask
`endif

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    reset           = 1'b1;
    bus_if.enable   = 1'b0;
    bus_if.load     = 1'b0;
    bus_if.period   = 10'd0;
    bus_if.prescale = 8'd0;
    bus_if.duty     = 40'd0;
    test_reset();
`ifdef PWM_CENTER_ALIGNED_EN
    test_center();
`else
    test_stopped_load();
    test_prescale();
    test_midperiod_reload();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
